// File: rtl/mat_loader_pkg.sv
// Shared sizes and operand packing helpers for the matrix loader.
package mat_loader_pkg;

   localparam int unsigned DW          = 32;
   localparam int unsigned MAT_DIM     = 4;
   localparam int unsigned MAT_WORDS   = MAT_DIM * MAT_DIM;
   localparam int unsigned FRAME_WORDS = 2 * MAT_WORDS;
   localparam int unsigned IDX_W       = $clog2(FRAME_WORDS);
   localparam int unsigned BANK_IDX_W  = $clog2(MAT_WORDS);

   // Row-major element index of operand (row,col), both 1-based like m11..m44.
   function automatic int unsigned mat_idx(input int unsigned row, input int unsigned col);
      return (row - 1) * MAT_DIM + (col - 1);
   endfunction

   // Bit offset of operand (row,col) inside a flat MAT_WORDS*dw bus.
   function automatic int unsigned mat_off(input int unsigned row, input int unsigned col,
                                           input int unsigned dw);
      return mat_idx(row, col) * dw;
   endfunction

endpackage

// File: rtl/mat_loader_bank.sv
// 16-entry operand register bank: indexed write port, flat row-major read port.
module mat_bank #(
   parameter int unsigned DW = mat_loader_pkg::DW
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    we,
   input  logic [mat_loader_pkg::BANK_IDX_W-1:0]   idx,
   input  logic [DW-1:0]                           wdata,
   output logic [mat_loader_pkg::MAT_WORDS*DW-1:0] rdata
);
   import mat_loader_pkg::*;

   logic [DW-1:0] regs [MAT_WORDS];

   // Element storage; cleared by reset, one word written per enabled cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(MAT_WORDS); i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[idx] <= wdata;
      end
   end

   // Flatten into the operand packing used on the matmul ports (m11 in the low word).
   for (genvar r = 1; r <= int'(MAT_DIM); r++) begin : g_row
      for (genvar c = 1; c <= int'(MAT_DIM); c++) begin : g_col
         assign rdata[mat_off(r, c, DW) +: DW] = regs[mat_idx(r, c)];
      end
   end

endmodule

// File: rtl/mat_loader.sv
// Stream-to-operand loader: collects 32-word frames (M then N) into a shadow
// bank and transfers them to held operand registers with a load pulse, while
// the next frame fills the shadow during the hold window.
module mat_loader #(
   parameter int unsigned DW          = mat_loader_pkg::DW,
   parameter int unsigned HOLD_CYCLES = 24
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [DW-1:0]                           in_data,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic                                    in_last,
   output logic [mat_loader_pkg::MAT_WORDS*DW-1:0] m_out,
   output logic [mat_loader_pkg::MAT_WORDS*DW-1:0] n_out,
   output logic                                    load,
   output logic                                    frame_rst,
   output logic                                    busy,
   output logic                                    err_frame
);
   import mat_loader_pkg::*;

   localparam int unsigned     HW       = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
   localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLD_CYCLES);

   logic [IDX_W-1:0]        wr_idx;
   logic                    shadow_full;
   logic [HW-1:0]           hold_cnt;

   logic                    accept;
   logic                    at_last;
   logic                    frame_end;
   logic                    frame_err;
   logic                    xfer;
   logic                    we_m;
   logic                    we_n;
   logic [MAT_WORDS*DW-1:0] shadow_m;
   logic [MAT_WORDS*DW-1:0] shadow_n;

   // Ready depends only on reset and the shadow state, never on in_valid.
   assign in_ready = rst & ~shadow_full;
   assign busy     = (hold_cnt != '0) | shadow_full;

   // Handshake, framing and transfer decode.
   always_comb begin
      accept    = 1'b0;
      at_last   = 1'b0;
      frame_end = 1'b0;
      frame_err = 1'b0;
      xfer      = 1'b0;
      we_m      = 1'b0;
      we_n      = 1'b0;

      accept    = in_valid & in_ready;
      at_last   = (wr_idx == LAST_IDX);
      frame_end = accept & in_last & at_last;
      frame_err = accept & (in_last ^ at_last);
      xfer      = shadow_full & (hold_cnt == '0);
      we_m      = accept & ~wr_idx[IDX_W-1];
      we_n      = accept &  wr_idx[IDX_W-1];
   end

   mat_bank #(.DW(DW)) u_shadow_m (
      .clk   (clk),
      .rst   (rst),
      .we    (we_m),
      .idx   (wr_idx[BANK_IDX_W-1:0]),
      .wdata (in_data),
      .rdata (shadow_m)
   );

   mat_bank #(.DW(DW)) u_shadow_n (
      .clk   (clk),
      .rst   (rst),
      .we    (we_n),
      .idx   (wr_idx[BANK_IDX_W-1:0]),
      .wdata (in_data),
      .rdata (shadow_n)
   );

   // Frame fill pointer, shadow-full flag and sticky framing error.
   // A bad frame restarts the pointer; its partial words are simply overwritten.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_idx      <= '0;
         shadow_full <= 1'b0;
         err_frame   <= 1'b0;
      end else begin
         if (xfer) begin
            shadow_full <= 1'b0;
         end else if (frame_end) begin
            shadow_full <= 1'b1;
         end

         if (frame_err) begin
            err_frame <= 1'b1;
            wr_idx    <= '0;
         end else if (accept) begin
            wr_idx <= wr_idx + IDX_W'(1);
         end
      end
   end

   // Hold window: reloads on each transfer, counts down to zero and stays there.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (xfer) begin
         hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HW'(1);
      end
   end

   // Held operands and the load/frame_rst pulses; operands move only on a transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_out     <= '0;
         n_out     <= '0;
         load      <= 1'b0;
         frame_rst <= 1'b0;
      end else begin
         load      <= xfer;
         frame_rst <= xfer;
         if (xfer) begin
            m_out <= shadow_m;
            n_out <= shadow_n;
         end
      end
   end

endmodule
